// File: rtl/axi4_wr_slave_arbiter.sv
// Per-slave AXI4 write-channel arbiter: grants one master and holds the grant through its AW, W and B phases.
// Optional macro AXI4_WR_ARB_QOS_EN: highest AWQOS wins, with ties broken in round-robin order.
//
// state | meaning
// IDLE  | no grant; arbitrate any pending request
// ADDR  | granted master's AW handshake pending
// DATA  | W burst in progress until the WLAST beat
// RESP  | waiting for the B handshake, then release
module axi4_wr_slave_arbiter #(
   parameter int NUM_MASTERS = 16,
   parameter int IDX_W       = $clog2(NUM_MASTERS),
   parameter int QOS_W       = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_MASTERS-1:0]       req_valid,
   input  logic [NUM_MASTERS*QOS_W-1:0] req_qos,
   input  logic                         s_awready,
   input  logic                         s_wvalid,
   input  logic                         s_wready,
   input  logic                         s_wlast,
   input  logic                         s_bvalid,
   input  logic                         s_bready,
   output logic [NUM_MASTERS-1:0]       grant,
   output logic [IDX_W-1:0]             grant_id,
   output logic                         aw_phase,
   output logic                         w_phase,
   output logic                         b_phase,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                   r_state, w_state_nxt;
   logic [NUM_MASTERS-1:0]   r_grant, w_grant_nxt;
   logic [IDX_W-1:0]         r_grant_id, w_grant_id_nxt;
   logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
   logic [IDX_W-1:0]         w_win_id;
   logic                     w_win_found;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      return IDX_W'(s);
   endfunction

`ifdef AXI4_WR_ARB_QOS_EN
   logic [QOS_W-1:0] w_best_qos;

   // Strictly-greater compare keeps the earliest round-robin candidate on QoS ties.
   always_comb begin
      w_win_id    = '0;
      w_win_found = 1'b0;
      w_best_qos  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (req_valid[rr_idx(r_rr_ptr, k)] &&
             (!w_win_found || req_qos[int'(rr_idx(r_rr_ptr, k))*QOS_W +: QOS_W] > w_best_qos)) begin
            w_win_found = 1'b1;
            w_win_id    = rr_idx(r_rr_ptr, k);
            w_best_qos  = req_qos[int'(rr_idx(r_rr_ptr, k))*QOS_W +: QOS_W];
         end
      end
   end
`else
   logic w_unused_qos;
   assign w_unused_qos = ^req_qos;

   always_comb begin
      w_win_id    = '0;
      w_win_found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (req_valid[rr_idx(r_rr_ptr, k)] && !w_win_found) begin
            w_win_found = 1'b1;
            w_win_id    = rr_idx(r_rr_ptr, k);
         end
      end
   end
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_grant_id_nxt = r_grant_id;
      w_rr_ptr_nxt   = r_rr_ptr;
      case (r_state)
         IDLE: begin
            if (w_win_found) begin
               w_grant_nxt    = NUM_MASTERS'(1) << w_win_id;
               w_grant_id_nxt = w_win_id;
               w_state_nxt    = ADDR;
            end
         end
         // A granted master dropping AWVALID simply stalls here; no re-arbitration.
         ADDR: if (req_valid[r_grant_id] && s_awready) w_state_nxt = DATA;
         DATA: if (s_wvalid && s_wready && s_wlast) w_state_nxt = RESP;
         RESP: begin
            if (s_bvalid && s_bready) begin
               w_state_nxt  = IDLE;
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = (r_grant_id == IDX_W'(NUM_MASTERS-1)) ? '0 : r_grant_id + IDX_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   assign grant    = r_grant;
   assign grant_id = r_grant_id;
   assign aw_phase = (r_state == ADDR);
   assign w_phase  = (r_state == DATA);
   assign b_phase  = (r_state == RESP);
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_axi4_wr_slave_arbiter.sv
// Scoreboard bench for axi4_wr_slave_arbiter: randomized masters/slave against a transaction-level arbitration model.
module tb_axi4_wr_slave_arbiter;
   localparam int N  = 16;
   localparam int IW = 4;
   localparam int QW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*QW-1:0] req_qos = '0;
   logic            s_awready = 1'b0, s_wvalid = 1'b0, s_wready = 1'b0, s_wlast = 1'b0;
   logic            s_bvalid = 1'b0, s_bready = 1'b0;
   logic [N-1:0]    grant;
   logic [IW-1:0]   grant_id;
   logic            aw_phase, w_phase, b_phase, busy;

   axi4_wr_slave_arbiter #(.NUM_MASTERS(N), .IDX_W(IW), .QOS_W(QW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_qos(req_qos),
      .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant(grant), .grant_id(grant_id), .aw_phase(aw_phase), .w_phase(w_phase),
      .b_phase(b_phase), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];
   int exp_phase = 0;     // 0 idle, 1 address, 2 data, 3 response
   int rr_model = 0;
   int cur_gid = -1;
   int mon_e;
   bit prev_nz = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] phase_code(input int ph);
      case (ph)
         1:       return 4'b1001;
         2:       return 4'b0101;
         3:       return 4'b0011;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic int model_winner(input logic [N-1:0] p);
`ifdef AXI4_WR_ARB_QOS_EN
      int best;
      best = -1;
      for (int i = 0; i < N; i++)
         if (p[i] && int'(req_qos[i*QW +: QW]) > best) best = int'(req_qos[i*QW +: QW]);
      for (int k = 0; k < N; k++)
         if (p[(rr_model + k) % N] && int'(req_qos[((rr_model + k) % N)*QW +: QW]) == best)
            return (rr_model + k) % N;
`else
      for (int k = 0; k < N; k++)
         if (p[(rr_model + k) % N]) return (rr_model + k) % N;
`endif
      return -1;
   endfunction

   // Monitor: pops an expected winner whenever a new grant appears, checks phases every cycle.
   always @(negedge clk) begin
      if (!rst_n) prev_nz = 1'b0;
      else begin
         if (grant != '0 && !prev_nz) begin
            if (exp_q.size() == 0) chk("grant_unexpected", 32'(grant), 32'h0);
            else begin
               mon_e = exp_q.pop_front();
               chk("grant_id", 32'(grant_id), 32'(mon_e));
               chk("grant_onehot", 32'(grant), 32'(1) << mon_e);
               cur_gid = mon_e;
            end
         end else if (grant != '0) chk("grant_hold", 32'(grant_id), 32'(cur_gid));
         chk("phase", 32'({aw_phase, w_phase, b_phase, busy}), 32'(phase_code(exp_phase)));
         if (exp_phase == 0) chk("grant_idle", 32'(grant), 32'h0);
         prev_nz = (grant != '0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage_w();
      s_wvalid = 1'($urandom);
      s_wready = 1'($urandom);
      s_wlast  = 1'($urandom);
   endtask

   task automatic garbage_b();
      s_bvalid = 1'($urandom);
      s_bready = 1'($urandom);
   endtask

   task automatic txn(input logic [N-1:0] p, input int nbeats, input int aw_stall,
                      input int b_stall, input bit rand_drop);
      int  w, beats, cnt;
      bit  drop, hs;
      w = model_winner(p);
      exp_q.push_back(w);
      req_valid = p;
      s_awready = 1'($urandom);
      garbage_w();
      garbage_b();
      cyc();
      exp_phase = 1;
      cnt = 0;
      hs  = 1'b0;
      while (!hs) begin
         drop = rand_drop && ($urandom % 4 == 0);
         req_valid = drop ? (p & ~(N'(1) << w)) : p;
         s_awready = (aw_stall >= 0) ? (cnt >= aw_stall) : 1'($urandom);
         garbage_w();
         garbage_b();
         hs = s_awready && !drop;
         cyc();
         cnt++;
      end
      exp_phase = 2;
      req_valid = p;
      beats = 0;
      while (beats < nbeats) begin
         s_awready = 1'($urandom);
         s_wvalid  = ($urandom % 4 != 0);
         s_wready  = ($urandom % 4 != 0);
         s_wlast   = s_wvalid ? (beats == nbeats - 1) : 1'($urandom);
         garbage_b();
         hs = s_wvalid && s_wready;
         cyc();
         if (hs) beats++;
      end
      exp_phase = 3;
      cnt = 0;
      hs  = 1'b0;
      while (!hs) begin
         if (b_stall >= 0) begin
            s_bvalid = 1'b1;
            s_bready = (cnt >= b_stall);
         end else garbage_b();
         garbage_w();
         hs = s_bvalid && s_bready;
         cyc();
         cnt++;
      end
      exp_phase = 0;
      rr_model  = (w == N - 1) ? 0 : w + 1;
      req_valid = '0;
      s_bvalid  = 1'b0;
      s_bready  = 1'b0;
   endtask

   task automatic reset_mid_data();
      int w;
      w = model_winner(16'h0200);
      exp_q.push_back(w);
      req_valid = 16'h0200;
      s_wvalid = 1'b0; s_bvalid = 1'b0; s_awready = 1'b0;
      cyc();
      exp_phase = 1;
      s_awready = 1'b1;
      cyc();
      exp_phase = 2;
      s_awready = 1'b0;
      s_wvalid = 1'b1; s_wready = 1'b1; s_wlast = 1'b0;
      cyc();
      rst_n = 1'b0;
      exp_phase = 0;
      rr_model = 0;
      #1;
      chk("rst_async_grant", 32'(grant), 32'h0);
      chk("rst_async_wphase", 32'(w_phase), 32'h0);
      chk("rst_async_busy", 32'(busy), 32'h0);
      req_valid = '0;
      s_wvalid = 1'b0; s_wlast = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] p;
      repeat (3) cyc();
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_grant_id", 32'(grant_id), 32'h0);
      chk("reset_phases", 32'({aw_phase, w_phase, b_phase, busy}), 32'h0);
      rst_n = 1'b1;
      cyc();

`ifdef AXI4_WR_ARB_QOS_EN
      req_qos = '0;
      req_qos[0*QW +: QW] = 4'd1;
      req_qos[1*QW +: QW] = 4'd9;
      req_qos[2*QW +: QW] = 4'd9;
      txn(16'h0007, 1, 0, 0, 1'b0);
      txn(16'h0007, 1, 0, 0, 1'b0);
      req_qos = '0;
      rst_n = 1'b0;
      rr_model = 0;
      cyc();
      rst_n = 1'b1;
      cyc();
`endif

      for (int i = 0; i < 17; i++) txn(16'hFFFF, 1, 0, 0, 1'b0);
      txn(16'h0004, 4, 0, 0, 1'b0);
      txn(16'h4000, 2, 0, 0, 1'b0);
      txn(16'h8001, 1, 0, 0, 1'b0);
      txn(16'h8001, 1, 0, 0, 1'b0);
      txn(16'h0100, 2, 10, 5, 1'b0);
      reset_mid_data();
      txn(16'h0010, 3, -1, -1, 1'b1);

      for (int i = 0; i < 300; i++) begin
         req_qos = {$urandom, $urandom};
         if ($urandom % 4 == 0) begin
            repeat ($urandom_range(1, 3)) begin
               req_valid = '0;
               s_awready = 1'($urandom);
               garbage_w();
               garbage_b();
               cyc();
            end
         end
         case ($urandom % 3)
            0:       p = N'(1) << $urandom_range(0, N - 1);
            1:       p = N'($urandom);
            default: p = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
         endcase
         if (p == '0) p = N'(1);
         txn(p, $urandom_range(1, 8), -1, -1, 1'b1);
      end

      repeat (3) cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
